// File: rtl/sck_burst_gen_pkg.sv
// Shared types and default widths for the serial-clock burst generator.
package sck_burst_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DIV_W = 16;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/sck_prescaler.sv
// Half-period prescaler: counts 0..div_i while enabled and flags the wrap cycle.
module sck_prescaler
    import sck_burst_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q;

    // Terminal count is compared, never reached by overflow, so div_i at full scale wraps cleanly.
    assign tc_o = en_i && (cnt_q == div_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tc_o ? '0 : cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sck_burst_gen.sv
// Programmable serial-clock generator with CPOL, burst length / free-run and
// graceful stop; all outputs come straight from registers.
module sck_burst_gen
    import sck_burst_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_fpga,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic [CNT_W-1:0] n_cycles,
    output logic             sck,
    output logic             sck_lead,
    output logic             sck_trail,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic             cpol_q;
    logic [CNT_W-1:0] ncyc_q;
    logic [CNT_W-1:0] periods_q;
    logic [CNT_W-1:0] periods_d;
    logic             stop_pend_q;
    logic             sck_q;
    logic             lead_q;
    logic             trail_q;
    logic             done_q;
    logic             tc;
    logic             stop_req;
    logic             sck_active;

    sck_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk_i   (clk_fpga),
        .rst_i   (rst),
        .clear_i (state_q == ST_IDLE),
        .en_i    (state_q == ST_RUN),
        .div_i   (div_q),
        .tc_o    (tc)
    );

    assign periods_d  = periods_q + CNT_W'(1);
    assign stop_req   = stop || stop_pend_q;
    assign sck_active = sck_q ^ cpol_q;

    // A stop seen while sck rests at idle ends the burst at once, pre-empting any lead toggle;
    // with sck active it waits for the trailing toggle so the last period stays whole.
    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cpol_q      <= 1'b0;
            ncyc_q      <= '0;
            periods_q   <= '0;
            stop_pend_q <= 1'b0;
            sck_q       <= 1'b0;
            lead_q      <= 1'b0;
            trail_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    sck_q <= cpol_q;
                    if (start) begin
                        div_q       <= div;
                        cpol_q      <= cpol;
                        ncyc_q      <= n_cycles;
                        sck_q       <= cpol;
                        periods_q   <= '0;
                        stop_pend_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (stop_req && !sck_active) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        stop_pend_q <= 1'b0;
                    end else if (tc) begin
                        sck_q <= ~sck_q;
                        if (!sck_active) begin
                            lead_q <= 1'b1;
                        end else begin
                            trail_q   <= 1'b1;
                            periods_q <= periods_d;
                            if (stop_req || (ncyc_q != '0 && periods_d == ncyc_q)) begin
                                state_q     <= ST_IDLE;
                                done_q      <= 1'b1;
                                stop_pend_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sck       = sck_q;
    assign sck_lead  = lead_q;
    assign sck_trail = trail_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_sck_burst_gen.sv
// Directed bench for sck_burst_gen: a timeline model of each burst predicts every output
// each cycle, and literal spot checks pin the model to hand-computed edges.
module tb_sck_burst_gen;

    localparam int DIV_W = 10;
    localparam int CNT_W = 8;
    localparam int NEVER = 32'h7fffffff;

    logic             clk_fpga = 1'b0;
    logic             rst      = 1'b1;
    logic             start    = 1'b0;
    logic             stop     = 1'b0;
    logic [DIV_W-1:0] div      = '0;
    logic             cpol     = 1'b0;
    logic [CNT_W-1:0] n_cycles = '0;
    logic             sck;
    logic             sck_lead;
    logic             sck_trail;
    logic             busy;
    logic             done;

    int nAssert = 0;
    int nFail   = 0;
    int cyc     = 0;

    // Model of the current burst as a timeline: start edge, half period, end edge.
    bit mActive  = 1'b0;
    bit mCpol    = 1'b0;
    bit mIdleLvl = 1'b0;
    bit mStopIdle = 1'b0;
    int mStart   = 0;
    int mEnd     = NEVER;
    int mHalf    = 1;
    int kPrev, kNow, cand;
    bit candIdle;

    bit expSck, expLead, expTrail, expBusy, expDone;
    int kc, tc;

    sck_burst_gen #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_fpga  (clk_fpga),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .cpol      (cpol),
        .n_cycles  (n_cycles),
        .sck       (sck),
        .sck_lead  (sck_lead),
        .sck_trail (sck_trail),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_fpga = ~clk_fpga;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Advance the model on every clock edge from the inputs the DUT also samples.
    always @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            mActive  = 1'b0;
            mIdleLvl = 1'b0;
        end else begin
            cyc++;
            if (mActive && cyc > mStart && cyc < mEnd && stop) begin
                kPrev = cyc - 1 - mStart;
                if (((kPrev / mHalf) % 2) == 0) begin
                    cand     = cyc;
                    candIdle = 1'b1;
                end else begin
                    kNow = cyc - mStart;
                    cand = ((kNow + mHalf - 1) / mHalf) * mHalf;
                    if (((cand / mHalf) % 2) == 1) cand += mHalf;
                    cand     += mStart;
                    candIdle = 1'b0;
                end
                if (cand < mEnd) begin
                    mEnd      = cand;
                    mStopIdle = candIdle;
                end
            end
            if (start && (!mActive || cyc > mEnd)) begin
                mActive   = 1'b1;
                mStart    = cyc;
                mHalf     = int'(div) + 1;
                mCpol     = cpol;
                mIdleLvl  = cpol;
                mStopIdle = 1'b0;
                mEnd      = (n_cycles == '0) ? NEVER : cyc + 2 * int'(n_cycles) * mHalf;
            end
        end
    end

    // Compare every output against the model half a clock after each edge.
    always @(negedge clk_fpga) begin
        expSck   = mIdleLvl;
        expLead  = 1'b0;
        expTrail = 1'b0;
        expBusy  = 1'b0;
        expDone  = 1'b0;
        if (mActive) begin
            if (cyc < mEnd) begin
                kc      = cyc - mStart;
                tc      = kc / mHalf;
                expSck  = mCpol ^ ((tc % 2) == 1);
                expBusy = 1'b1;
                if (kc > 0 && (kc % mHalf) == 0) begin
                    expLead  = ((tc % 2) == 1);
                    expTrail = ((tc % 2) == 0);
                end
            end else begin
                expSck = mCpol;
                if (cyc == mEnd) begin
                    expDone  = 1'b1;
                    expTrail = !mStopIdle;
                end
            end
        end
        checkOutput("model sck", sck, expSck);
        checkOutput("model sck_lead", sck_lead, expLead);
        checkOutput("model sck_trail", sck_trail, expTrail);
        checkOutput("model busy", busy, expBusy);
        checkOutput("model done", done, expDone);
    end

    // One-cycle start request; returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input int d, input bit c, input int n);
        @(negedge clk_fpga);
        div      = DIV_W'(d);
        cpol     = c;
        n_cycles = CNT_W'(n);
        start    = 1'b1;
        @(negedge clk_fpga);
        start    = 1'b0;
    endtask

    initial begin
        #12;
        checkOutput("reset sck", sck, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        @(negedge clk_fpga);
        #3 rst = 1'b0;

        // T1: div=3, cpol=0, n=2
        applyStimulus(3, 1'b0, 2);
        repeat (4) @(posedge clk_fpga);
        #1;
        checkOutput("T1 sck@4", sck, 1'b1);
        checkOutput("T1 lead@4", sck_lead, 1'b1);
        repeat (12) @(posedge clk_fpga);
        #1;
        checkOutput("T1 done@16", done, 1'b1);
        checkOutput("T1 trail@16", sck_trail, 1'b1);
        checkOutput("T1 busy@16", busy, 1'b0);
        @(posedge clk_fpga);
        #1;
        checkOutput("T1 done@17", done, 1'b0);
        repeat (3) @(negedge clk_fpga);

        // T2: div=0, cpol=1, n=3
        applyStimulus(0, 1'b1, 3);
        checkOutput("T2 sck idle", sck, 1'b1);
        @(posedge clk_fpga);
        #1;
        checkOutput("T2 lead@1", sck_lead, 1'b1);
        repeat (5) @(posedge clk_fpga);
        #1;
        checkOutput("T2 done@6", done, 1'b1);
        checkOutput("T2 sck@6", sck, 1'b1);
        repeat (3) @(negedge clk_fpga);

        // T3: free-run div=1, stop while active after 10 periods
        applyStimulus(1, 1'b0, 0);
        repeat (42) @(negedge clk_fpga);
        stop = 1'b1;
        @(negedge clk_fpga);
        stop = 1'b0;
        @(posedge clk_fpga);
        #1;
        checkOutput("T3 done@44", done, 1'b1);
        checkOutput("T3 sck@44", sck, 1'b0);
        repeat (3) @(negedge clk_fpga);
        // stop while sck idle, on the edge that would otherwise lead
        applyStimulus(1, 1'b0, 0);
        repeat (5) @(negedge clk_fpga);
        stop = 1'b1;
        @(negedge clk_fpga);
        stop = 1'b0;
        checkOutput("T3 idle stop done", done, 1'b1);
        checkOutput("T3 idle stop lead", sck_lead, 1'b0);
        checkOutput("T3 idle stop sck", sck, 1'b0);
        repeat (3) @(negedge clk_fpga);

        // T4: start during RUN ignored; start on the done edge ignored, accepted next cycle
        applyStimulus(3, 1'b0, 4);
        repeat (5) @(negedge clk_fpga);
        div      = DIV_W'(7);
        cpol     = 1'b1;
        n_cycles = CNT_W'(1);
        start    = 1'b1;
        @(negedge clk_fpga);
        start = 1'b0;
        repeat (6) @(posedge clk_fpga);
        #1;
        checkOutput("T4 lead@12", sck_lead, 1'b1);
        checkOutput("T4 sck@12", sck, 1'b1);
        @(negedge clk_fpga);
        repeat (19) @(negedge clk_fpga);
        div      = DIV_W'(1);
        cpol     = 1'b0;
        n_cycles = CNT_W'(1);
        start    = 1'b1;
        @(posedge clk_fpga);
        #1;
        checkOutput("T4 done@32", done, 1'b1);
        checkOutput("T4 busy@32", busy, 1'b0);
        @(negedge clk_fpga);
        @(posedge clk_fpga);
        #1;
        checkOutput("T4 busy@33", busy, 1'b1);
        @(negedge clk_fpga);
        start = 1'b0;
        repeat (8) @(negedge clk_fpga);
        div      = DIV_W'(2);
        cpol     = 1'b1;
        n_cycles = CNT_W'(1);
        start    = 1'b1;
        stop     = 1'b1;
        @(negedge clk_fpga);
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("T4 start+stop busy", busy, 1'b1);
        checkOutput("T4 start+stop sck", sck, 1'b1);
        repeat (10) @(negedge clk_fpga);

        // T5: asynchronous reset mid-burst
        applyStimulus(4, 1'b1, 0);
        repeat (12) @(negedge clk_fpga);
        checkOutput("T5 pre sck", sck, 1'b1);
        checkOutput("T5 pre busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("T5 rst sck", sck, 1'b0);
        checkOutput("T5 rst busy", busy, 1'b0);
        checkOutput("T5 rst done", done, 1'b0);
        checkOutput("T5 rst lead", sck_lead, 1'b0);
        checkOutput("T5 rst trail", sck_trail, 1'b0);
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        #2 rst = 1'b0;
        applyStimulus(2, 1'b0, 2);
        repeat (3) @(posedge clk_fpga);
        #1;
        checkOutput("T5 lead@3", sck_lead, 1'b1);
        repeat (9) @(posedge clk_fpga);
        #1;
        checkOutput("T5 done@12", done, 1'b1);
        repeat (3) @(negedge clk_fpga);

        // T6: maximum divisor, one period
        applyStimulus((1 << DIV_W) - 1, 1'b0, 1);
        repeat ((1 << DIV_W) - 1) @(posedge clk_fpga);
        #1;
        checkOutput("T6 sck before lead", sck, 1'b0);
        @(posedge clk_fpga);
        #1;
        checkOutput("T6 lead@max", sck_lead, 1'b1);
        checkOutput("T6 sck@max", sck, 1'b1);
        repeat (1 << DIV_W) @(posedge clk_fpga);
        #1;
        checkOutput("T6 done@2max", done, 1'b1);
        checkOutput("T6 trail@2max", sck_trail, 1'b1);
        checkOutput("T6 sck@2max", sck, 1'b0);
        repeat (4) @(negedge clk_fpga);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
